// File: rtl/question_part_5.sv
// question_part_5 -- registered 7-input population count.
//
// Counts the ones in {a6..a0} with a 7-to-3 full-adder compressor and
// registers the 3-bit result, so the output follows the input by one clock.
//
// Ports:
//   a6..a0 : data word (a6 = MSB)
//   y2..y0 : registered count of ones (y2 = MSB), range 0..7
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears the count

// Full adder used four times by the compressor.
module question_part_5_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module question_part_5 (
  input  logic a6,
  input  logic a5,
  input  logic a4,
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  output logic y2,
  output logic y1,
  output logic y0,
  input  logic clk,
  input  logic rst
);
  logic s1, c1, s2, c2, c3;
  logic y0_next, y1_next, y2_next;
  logic [2:0] cmp_cnt;   // compressor result, drives the outputs
  logic [2:0] ref_cnt;   // behavioural count, used only for self-checking
  logic [2:0] cnt_q;

  // Two 3:2 stages on the data, then a third folds in a6; the three
  // weight-2 carries are summed by the last adder into bits 1 and 2.
  question_part_5_fa fa1 (.x(a0), .y(a1), .z(a2), .s(s1),      .c(c1));
  question_part_5_fa fa2 (.x(a3), .y(a4), .z(a5), .s(s2),      .c(c2));
  question_part_5_fa fa3 (.x(s1), .y(s2), .z(a6), .s(y0_next), .c(c3));
  question_part_5_fa fa4 (.x(c1), .y(c2), .z(c3), .s(y1_next), .c(y2_next));

  assign cmp_cnt = {y2_next, y1_next, y0_next};

  assign ref_cnt = {2'b0, a6} + {2'b0, a5} + {2'b0, a4} + {2'b0, a3}
                 + {2'b0, a2} + {2'b0, a1} + {2'b0, a0};

  // Outputs always take the compressor; a disagreement only raises an
  // assertion and never alters the data path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cmp_cnt == ref_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 3'b000;
    else     cnt_q <= cmp_cnt;
  end

  assign y2 = cnt_q[2];
  assign y1 = cnt_q[1];
  assign y0 = cnt_q[0];
endmodule

// File: tb/tb_question_part_5.sv
// Self-checking bench for question_part_5: reset, directed vectors,
// boundaries, exhaustive sweep, mid-stream reset, latency and random traffic.
module tb_question_part_5;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] a   = 7'd0;
  wire  [2:0] y;
  int checks   = 0;
  int failures = 0;

  question_part_5 dut (
    .a6(a[6]), .a5(a[5]), .a4(a[4]), .a3(a[3]), .a2(a[2]), .a1(a[1]), .a0(a[0]),
    .y2(y[2]), .y1(y[1]), .y0(y[0]),
    .clk(clk), .rst(rst)
  );

  always #5 clk = ~clk;

  // Reference: number of set bits, counted one at a time.
  function automatic logic [2:0] pop(input logic [6:0] w);
    int n = 0;
    for (int i = 0; i < 7; i++) if (w[i]) n++;
    return 3'(n);
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present w before the next edge, then look at the output 1 time unit after it.
  task automatic step(input logic [6:0] w, input logic r, input string tag);
    logic [2:0] exp;
    @(negedge clk);
    a   = w;
    rst = r;
    exp = r ? 3'd0 : pop(w);
    @(posedge clk);
    #1;
    check(tag, y, exp);
  endtask

  logic [6:0] vec [9] = '{7'b0100110, 7'b1110010, 7'b0111110, 7'b0111100,
                          7'b0100101, 7'b0011101, 7'b0000001, 7'b0110010,
                          7'b0000000};
  int         vexp [9] = '{3, 4, 5, 4, 3, 4, 1, 3, 0};

  initial begin
    // Reset with non-zero data present: output must be cleared.
    step(7'b1111111, 1'b1, "reset_ones");
    step(7'b1010101, 1'b1, "reset_mixed");

    // First edge after reset loads the count directly.
    step(7'b0100110, 1'b0, "first_after_reset");

    // Directed vectors with constant expectations.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a = vec[i];
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), y, 3'(vexp[i]));
    end

    // Boundaries: all ones, all zeros, every one-hot word.
    @(negedge clk); a = 7'b1111111; @(posedge clk); #1;
    check("all_ones", y, 3'b111);
    @(negedge clk); a = 7'b0000000; @(posedge clk); #1;
    check("all_zeros", y, 3'b000);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); a = 7'd1 << i; @(posedge clk); #1;
      check($sformatf("onehot%0d", i), y, 3'd1);
    end

    // Exhaustive sweep: compressor and behavioural counts before the
    // edge, registered output after it.
    for (int w = 0; w < 128; w++) begin
      @(negedge clk);
      a = 7'(w);
      #1;
      check($sformatf("cmp_%0d", w), dut.cmp_cnt, pop(7'(w)));
      check($sformatf("ref_%0d", w), dut.ref_cnt, pop(7'(w)));
      @(posedge clk);
      #1;
      check($sformatf("sweep_%0d", w), y, pop(7'(w)));
    end

    // Mid-stream reset held for two cycles, then release.
    step(7'b1111111, 1'b0, "pre_reset_7");
    step(7'b1111111, 1'b1, "mid_reset_c1");
    step(7'b1111111, 1'b1, "mid_reset_c2");
    step(7'b1111111, 1'b0, "post_reset_7");

    // Latency: an input change right after an edge is invisible until the next edge.
    step(7'b0000000, 1'b0, "lat_zero");
    a = 7'b0111110;
    #2;
    check("lat_hold", y, 3'd0);
    @(negedge clk);
    check("lat_hold_neg", y, 3'd0);
    @(posedge clk);
    #1;
    check("lat_update", y, 3'd5);

    // Glitching between edges: only the value present at the edge counts.
    @(negedge clk);
    a = 7'b1111111;
    #2 a = 7'b0000011;
    @(posedge clk);
    #1;
    check("glitch_edge_value", y, 3'd2);

    // Random traffic with occasional reset.
    for (int i = 0; i < 200; i++)
      step(7'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0),
           $sformatf("rand%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/question_part_5.md
QUESTION_PART_5 -- requirements
Module: question_part_5

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the sole clock; all state updates occur on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and be a synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Ports a6, a5, a4, a3, a2, a1, a0 SHALL each be an input, 1 bit wide, and together form the data word, with a6 as the MSB and a0 as the LSB.
REQ-005 Ports y2, y1, y0 SHALL each be an output, 1 bit wide, and together form the registered 3-bit count, with y2 as the MSB.
REQ-006 The port order SHALL be a6, a5, a4, a3, a2, a1, a0, y2, y1, y0, clk, rst, so that positional instantiation of the first ten ports matches the data/count ordering.
REQ-007 The block SHALL have no parameters; all widths are fixed.

Function
REQ-008 The block SHALL compute N, the number of inputs among a6..a0 equal to 1, in the range 0..7, encoded as unsigned binary {y2,y1,y0}.
REQ-009 The count SHALL be formed combinationally by a 7-to-3 full-adder compressor.
- FA1 = (a0, a1, a2) -> s1, c1
- FA2 = (a3, a4, a5) -> s2, c2
- FA3 = (s1, s2, a6) -> y0_next, c3
- FA4 = (c1, c2, c3) -> y1_next (sum), y2_next (carry)
REQ-010 Each full adder SHALL implement sum = x XOR y XOR z and carry = majority(x, y, z).
REQ-011 The full adder SHALL be a separate reusable submodule instantiated four times.
REQ-012 The block SHALL also compute a reference count by a behavioural sum of the seven bits zero-extended to 3 bits.
REQ-013 When the compressor result differs from the reference count, the block SHALL drive the compressor result to the outputs unchanged; the reference count serves only as an internal assertion-check signal.
REQ-014 {y2,y1,y0} SHALL be registered: on each rising clk edge with rst=0, the outputs take the count of the inputs sampled at that edge.
REQ-015 Latency from input to output SHALL be exactly 1 clock cycle.
REQ-016 There SHALL be no handshake: a new input word is accepted every cycle.
REQ-017 The count SHALL never overflow: the maximum value 7 (all ones) yields 3'b111, and all zeros yields 3'b000.
REQ-018 Inputs that change between clock edges SHALL NOT affect the outputs until the next rising edge.
REQ-019 X or Z values on the inputs are outside the contract; verification drives only 0 and 1.

Reset
REQ-020 When rst=1 at a rising clk edge, {y2,y1,y0} SHALL become 3'b000 regardless of the inputs.
REQ-021 Reset SHALL take priority over the data path on the same edge.
REQ-022 When rst is deasserted, the first edge with rst=0 SHALL load the count of the inputs present at that edge; there is no additional warm-up cycle.
REQ-023 Asserting rst mid-stream SHALL clear the outputs on that edge, and the outputs SHALL remain 0 for as long as rst stays high.

Verification
REQ-024 Vector sequence, each held for one or more cycles, with the output checked one cycle after each is applied:
- 0100110 -> 3
- 1110010 -> 4
- 0111110 -> 5
- 0111100 -> 4
- 0100101 -> 3
- 0011101 -> 4
- 0000001 -> 1
- 0110010 -> 3
- 0000000 -> 0
REQ-025 Boundary cases: 1111111 -> 7 (3'b111); each one-hot input (for example a6 alone, a0 alone) -> 1.
REQ-026 Exhaustive sweep of all 128 input words: the output SHALL equal the popcount for every word, and the compressor result SHALL equal the internal reference count.
REQ-027 Reset mid-operation: with input 1111111 and the output at 7, assert rst for 2 cycles -> output is 0 on both cycles; deassert rst -> output is 7 on the next edge.
REQ-028 Latency check: change the input from 0000000 to 0111110 just after an edge -> the output stays 0 until the next rising edge, then becomes 5.
